// File: rtl/mmio_port_responder_if.sv
// Data-memory bus bundle (address/store/load strobes and the responder's read-back and hit).
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO port responder: OUT_DATA / IN_DATA / EDGE_STATUS (W1C) / EDGE_ENABLE with registered Irq.
// Optional input debounce filter enabled by defining PORT_DEBOUNCE_EN.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0400,
  parameter int          IN_WIDTH        = 8,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0]  PortIn,
  output logic [31:0]          PortOut,
  output logic                 Irq
);
  localparam logic [1:0] REG_OUT    = 2'd0;
  localparam logic [1:0] REG_IN     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_ENABLE = 2'd3;

  if (BASE_ADDR[3:0] != 4'h0) begin : gBadBase
    $error("BASE_ADDR must be 16-byte aligned");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic                hit;
  logic                wrEn;
  logic [1:0]          regSel;
  logic [IN_WIDTH-1:0] sync_p0;
  logic [IN_WIDTH-1:0] sync_p1;
  logic [IN_WIDTH-1:0] filtered;
  logic [IN_WIDTH-1:0] prevFiltered;
  logic [IN_WIDTH-1:0] edgeStatus;
  logic [IN_WIDTH-1:0] edgeEnable;
  logic [IN_WIDTH-1:0] rise;
  logic [IN_WIDTH-1:0] w1cMask;
  logic [IN_WIDTH-1:0] statusNext;

  assign regSel  = bus.Address[3:2];
  assign hit     = (bus.Address[31:4] == BASE_ADDR[31:4]) && (bus.Address[1:0] == 2'b00);
  assign bus.Hit = hit;
  assign wrEn    = hit && bus.MemWrite;

  // Reads see the current registers, so a same-cycle write is not yet visible
  always_comb begin
    bus.ReadData = '0;
    if (hit && bus.MemRead) begin
      case (regSel)
        REG_OUT:    bus.ReadData = PortOut;
        REG_IN:     bus.ReadData = 32'(filtered);
        REG_STATUS: bus.ReadData = 32'(edgeStatus);
        default:    bus.ReadData = 32'(edgeEnable);
      endcase
    end
  end

  assign rise       = filtered & ~prevFiltered;
  assign w1cMask    = (wrEn && (regSel == REG_STATUS)) ? bus.WriteData[IN_WIDTH-1:0] : '0;
  assign statusNext = (edgeStatus & ~w1cMask) | rise;

  // Stage p0/p1: two-flop synchronizer, then prev/status/enable/out/irq registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0      <= '0;
      sync_p1      <= '0;
      prevFiltered <= '0;
      edgeStatus   <= '0;
      edgeEnable   <= '0;
      PortOut      <= '0;
      Irq          <= 1'b0;
    end else begin
      sync_p0      <= PortIn;
      sync_p1      <= sync_p0;
      prevFiltered <= filtered;
      edgeStatus   <= statusNext;
      if (wrEn && (regSel == REG_ENABLE)) edgeEnable <= bus.WriteData[IN_WIDTH-1:0];
      if (wrEn && (regSel == REG_OUT))    PortOut    <= bus.WriteData;
      Irq          <= |(edgeStatus & edgeEnable);
    end
  end

`ifdef PORT_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] dbCnt [IN_WIDTH];

  // Filter stage: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      filtered <= '0;
      for (int i = 0; i < IN_WIDTH; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (sync_p1[i] == filtered[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == CNT_LAST) begin
          filtered[i] <= sync_p1[i];
          dbCnt[i]    <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign filtered = sync_p1;
`endif
endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: vector table, directed corner cases, random vs history model.
`timescale 1ns/1ps
module tb_mmio_port_responder;
  localparam logic [31:0] BASE  = 32'h1001_0400;
  localparam int          NRAND = 400;
`ifdef PORT_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mw;
    logic        mr;
    logic [7:0]  pin;
    logic        dbSkip;
    logic        expHit;
    logic [31:0] expRd;
    logic [31:0] expOut;
    logic        expIrq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl[20];

  // Reference history: state after edge n (index 0 = reset edge)
  logic [7:0]  mPin [0:NRAND];
  logic [7:0]  mFilt[0:NRAND];
  logic [7:0]  mStat[0:NRAND];
  logic [7:0]  mEn  [0:NRAND];
  logic [31:0] mOut [0:NRAND];
  logic        mIrq [0:NRAND];

  mmio_port_responder_if bus();

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq));

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic mw, input logic mr);
    bus.Address   = a;
    bus.WriteData = d;
    bus.MemWrite  = mw;
    bus.MemRead   = mr;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic mw,
                              input logic mr, input logic [7:0] pin, input logic sk,
                              input logic h, input logic [31:0] rd, input logic [31:0] po,
                              input logic irq);
    vec_t v;
    v.addr = a; v.wdata = d; v.mw = mw; v.mr = mr; v.pin = pin; v.dbSkip = sk;
    v.expHit = h; v.expRd = rd; v.expOut = po; v.expIrq = irq;
    return v;
  endfunction

  function automatic logic [7:0] pinAt(input int k);
    return (k < 1) ? 8'h00 : mPin[k];
  endfunction

  function automatic logic [7:0] filtAt(input int k);
    return (k < 0) ? 8'h00 : mFilt[k];
  endfunction

  initial begin
    logic [31:0] addr, wdata, expRd;
    logic [7:0]  pin, win, fNew;
    logic [1:0]  sel;
    logic        mw, mr, expHit, wr, flip;
    int          kind;

    tbl[0]  = mk(BASE+32'h0, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0);
    tbl[1]  = mk(BASE+32'h4, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0);
    tbl[2]  = mk(BASE+32'h8, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0);
    tbl[3]  = mk(BASE+32'hC, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0);
    tbl[4]  = mk(BASE+32'h0, 32'hDEADBEEF,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,         32'h0,         1'b0);
    tbl[5]  = mk(BASE+32'h0, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0);
    tbl[6]  = mk(BASE+32'h2, 32'h1234,      1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[7]  = mk(BASE+32'h0, 32'h0,         1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0);
    tbl[8]  = mk(BASE+32'hC, 32'hFFFFFF01,  1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[9]  = mk(BASE+32'hC, 32'h0,         1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 32'h1,         32'hDEADBEEF,  1'b0);
    tbl[10] = mk(BASE+32'h4, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[11] = mk(BASE+32'h4, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h1,         32'hDEADBEEF,  1'b0);
    tbl[12] = mk(BASE+32'h8, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h1,         32'hDEADBEEF,  1'b0);
    tbl[13] = mk(BASE+32'h8, 32'h1,         1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 32'h1,         32'hDEADBEEF,  1'b1);
    tbl[14] = mk(BASE+32'h8, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF,  1'b1);
    tbl[15] = mk(BASE+32'h8, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[16] = mk(BASE+32'h4, 32'h0,         1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[17] = mk(BASE+32'h4, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 32'h1,         32'hDEADBEEF,  1'b0);
    tbl[18] = mk(BASE+32'h10, 32'h0,        1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF,  1'b0);
    tbl[19] = mk(BASE+32'h5, 32'h0,         1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 32'h0,         32'hDEADBEEF,  1'b0);

    reset  = 1'b1;
    PortIn = 8'h00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      PortIn = tbl[i].pin;
      drive(tbl[i].addr, tbl[i].wdata, tbl[i].mw, tbl[i].mr);
      #1;
      if (!(tbl[i].dbSkip && (DB != 0))) begin
        check32($sformatf("row%0d_hit", i), {31'b0, bus.Hit}, {31'b0, tbl[i].expHit});
        check32($sformatf("row%0d_rdata", i), bus.ReadData, tbl[i].expRd);
        check32($sformatf("row%0d_portout", i), PortOut, tbl[i].expOut);
        check32($sformatf("row%0d_irq", i), {31'b0, Irq}, {31'b0, tbl[i].expIrq});
      end
      tick();
    end

    // A new rising edge landing on the same edge as a W1C of that bit keeps it set
    PortIn = 8'h00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (DB + 4) tick();
    drive(BASE+32'h8, 32'hFF, 1'b1, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h01;
    tick();
    repeat (DB + 1) tick();
    drive(BASE+32'h8, 32'h1, 1'b1, 1'b0);
    tick();
    drive(BASE+32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    check32("w1c_vs_rise", bus.ReadData, 32'h1);
    drive(BASE+32'h8, 32'h1, 1'b1, 1'b0);
    tick();
    drive(BASE+32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    check32("w1c_clears", bus.ReadData, 32'h0);

    // Reset during a store with all status bits set
    PortIn = 8'h00;
    drive(BASE+32'hC, 32'hFF, 1'b1, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (DB + 4) tick();
    PortIn = 8'hFF;
    repeat (DB + 3) tick();
    drive(BASE+32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    check32("status_all", bus.ReadData, 32'hFF);
    tick();
    check32("irq_all", {31'b0, Irq}, 32'h1);
    reset = 1'b1;
    drive(BASE+32'h0, 32'h5, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
    drive(BASE+32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    check32("rst_portout", PortOut, 32'h0);
    check32("rst_out_rd", bus.ReadData, 32'h0);
    check32("rst_irq", {31'b0, Irq}, 32'h0);
    drive(BASE+32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    check32("rst_status", bus.ReadData, 32'h0);
    drive(BASE+32'hC, 32'h0, 1'b0, 1'b1);
    #1;
    check32("rst_enable", bus.ReadData, 32'h0);

`ifdef PORT_DEBOUNCE_EN
    PortIn = 8'h00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    repeat (DB + 6) tick();
    drive(BASE+32'h8, 32'hFF, 1'b1, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    PortIn = 8'h02;
    repeat (3) tick();
    PortIn = 8'h00;
    repeat (DB + 6) tick();
    drive(BASE+32'h4, 32'h0, 1'b0, 1'b1);
    #1;
    check32("db_short_in", bus.ReadData, 32'h0);
    drive(BASE+32'h8, 32'h0, 1'b0, 1'b1);
    #1;
    check32("db_short_status", bus.ReadData, 32'h0);
    PortIn = 8'h02;
    repeat (6) tick();
    PortIn = 8'h00;
    repeat (DB + 6) tick();
    #1;
    check32("db_long_status", bus.ReadData, 32'h2);
`endif

    // Randomized traffic against the history model
    reset = 1'b1;
    PortIn = 8'h00;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    mPin[0] = 8'h00; mFilt[0] = 8'h00; mStat[0] = 8'h00; mEn[0] = 8'h00;
    mOut[0] = 32'h0; mIrq[0] = 1'b0;
    pin = 8'h00;

    for (int n = 1; n <= NRAND; n++) begin
      kind = $urandom_range(9);
      if (kind == 0) pin = 8'($urandom);
      else if (kind <= 2) pin[$urandom_range(7)] = ~pin[$urandom_range(7)];
      sel   = 2'($urandom_range(3));
      addr  = BASE + {28'h0, sel, 2'b00};
      wdata = $urandom;
      mw    = ($urandom_range(2) == 0);
      mr    = ($urandom_range(1) == 1);
      kind  = $urandom_range(9);
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = ($urandom_range(1) == 1) ? addr + 32'h10 : addr - 32'h10;
      expHit = (kind >= 2);
      expRd  = 32'h0;
      if (expHit && mr) begin
        case (sel)
          2'd0:    expRd = mOut[n-1];
          2'd1:    expRd = {24'h0, mFilt[n-1]};
          2'd2:    expRd = {24'h0, mStat[n-1]};
          default: expRd = {24'h0, mEn[n-1]};
        endcase
      end
      PortIn = pin;
      drive(addr, wdata, mw, mr);
      #1;
      check32($sformatf("rnd%0d_hit", n), {31'b0, bus.Hit}, {31'b0, expHit});
      check32($sformatf("rnd%0d_rdata", n), bus.ReadData, expRd);
      check32($sformatf("rnd%0d_portout", n), PortOut, mOut[n-1]);
      check32($sformatf("rnd%0d_irq", n), {31'b0, Irq}, {31'b0, mIrq[n-1]});

      mPin[n] = pin;
      if (DB == 0) begin
        mFilt[n] = pinAt(n - 1);
      end else begin
        fNew = mFilt[n-1];
        for (int b = 0; b < 8; b++) begin
          flip = 1'b1;
          for (int k = n - 1 - DB; k <= n - 2; k++) begin
            win = pinAt(k);
            if (win[b] == mFilt[n-1][b]) flip = 1'b0;
          end
          if (flip) fNew[b] = ~fNew[b];
        end
        mFilt[n] = fNew;
      end
      wr       = expHit && mw;
      mStat[n] = (mStat[n-1] & ~((wr && sel == 2'd2) ? wdata[7:0] : 8'h00))
                 | (filtAt(n - 1) & ~filtAt(n - 2));
      mEn[n]   = (wr && sel == 2'd3) ? wdata[7:0] : mEn[n-1];
      mOut[n]  = (wr && sel == 2'd0) ? wdata : mOut[n-1];
      mIrq[n]  = |(mStat[n-1] & mEn[n-1]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
